// File: rtl/alu_exec_stage.sv
// Execute stage: single-cycle ALU/address/branch ops, multi-cycle MUL, decode
// stall/bypass handshake and registered results toward the cache stage.
package alu_exec_pkg;
   localparam int PC_WIDTH = 32;

   localparam logic [6:0] OP_NOP  = 7'd0;
   localparam logic [6:0] OP_ADD  = 7'd1;
   localparam logic [6:0] OP_SUB  = 7'd2;
   localparam logic [6:0] OP_MUL  = 7'd3;
   localparam logic [6:0] OP_ADDI = 7'd4;
   localparam logic [6:0] OP_LDB  = 7'd5;
   localparam logic [6:0] OP_LDW  = 7'd6;
   localparam logic [6:0] OP_STB  = 7'd7;
   localparam logic [6:0] OP_STW  = 7'd8;
   localparam logic [6:0] OP_BEQ  = 7'd9;
   localparam logic [6:0] OP_JUMP = 7'd10;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd_addr;
      logic [4:0]  ra_addr;
      logic [31:0] ra_data;
      logic [31:0] rb_data;
      logic [31:0] offset;
   } alu_request_t;
endpackage

module alu_exec_stage
   import alu_exec_pkg::*;
#(
   parameter int unsigned MUL_LATENCY = 5
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req_to_alu_valid,
   input  alu_request_t        req_to_alu_info,
   input  logic [PC_WIDTH-1:0] req_to_alu_pc,
   input  logic                cache_stall,
   output logic                stall_decode,
   output logic [31:0]         alu_data_bypass,
   output logic                branch_taken,
   output logic [31:0]         branch_target,
   output logic                req_to_cache_valid,
   output logic [6:0]          req_to_cache_opcode,
   output logic [4:0]          req_to_cache_rd_addr,
   output logic [31:0]         req_to_cache_result,
   output logic [31:0]         req_to_cache_st_data,
   output logic [31:0]         req_to_cache_pc,
   output logic                xcpt_overflow
);

   typedef enum logic {IDLE, MUL_BUSY} state_t;

   localparam logic [3:0] CNT_INIT = 4'(MUL_LATENCY - 1);

   state_t       state, state_next;
   logic [3:0]   mul_cnt, mul_cnt_next;
   logic         kill, replay;
   logic [31:0]  mul_a, mul_b, mul_pc;
   logic [4:0]   mul_rd;

   logic [6:0]   op;
   logic [31:0]  ra, rb, off;
   logic [31:0]  alu_res, st_data;
   logic         alu_ovf, writes, bypass_ok, take;
   logic         busy, is_mul, replay_hit, blocked, accept, mul_start, mul_done;
   logic signed [63:0] mul_prod;
   logic         mul_ovf;
   logic         unused_ra_addr;

   assign op  = req_to_alu_info.opcode;
   assign ra  = req_to_alu_info.ra_data;
   assign rb  = req_to_alu_info.rb_data;
   assign off = req_to_alu_info.offset;
   assign unused_ra_addr = ^req_to_alu_info.ra_addr;

   // Decode re-presents the held MUL when stall falls; that copy must not run twice.
   assign busy       = (state == MUL_BUSY);
   assign is_mul     = req_to_alu_valid & (op == OP_MUL);
   assign replay_hit = replay & req_to_alu_valid & (req_to_alu_pc == mul_pc);
   assign blocked    = kill | replay_hit;

   assign stall_decode = (~busy & is_mul & ~blocked) | busy | cache_stall;
   assign accept       = req_to_alu_valid & ~stall_decode & ~blocked;
   assign mul_start    = ~busy & is_mul & ~blocked & ~cache_stall;
   assign mul_done     = busy & (mul_cnt == 4'd1) & ~cache_stall;

   always_comb begin
      alu_res   = '0;
      st_data   = '0;
      alu_ovf   = 1'b0;
      writes    = 1'b0;
      bypass_ok = 1'b0;
      take      = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res   = ra + rb;
            alu_ovf   = (ra[31] == rb[31]) & (alu_res[31] != ra[31]);
            writes    = 1'b1;
            bypass_ok = 1'b1;
         end
         OP_SUB: begin
            alu_res   = ra - rb;
            alu_ovf   = (ra[31] != rb[31]) & (alu_res[31] != ra[31]);
            writes    = 1'b1;
            bypass_ok = 1'b1;
         end
         OP_ADDI: begin
            alu_res   = ra + off;
            alu_ovf   = (ra[31] == off[31]) & (alu_res[31] != ra[31]);
            writes    = 1'b1;
            bypass_ok = 1'b1;
         end
         OP_LDB, OP_LDW: begin
            alu_res = ra + off;
            writes  = 1'b1;
         end
         OP_STB, OP_STW: begin
            alu_res = ra + off;
            st_data = rb;
            writes  = 1'b1;
         end
         OP_BEQ:  take = (ra == rb);
         OP_JUMP: take = 1'b1;
         default: ;
      endcase
   end

   assign alu_data_bypass = (req_to_alu_valid & bypass_ok) ? alu_res : '0;

   assign mul_prod = $signed(mul_a) * $signed(mul_b);
   assign mul_ovf  = (mul_prod[63:32] != {32{mul_prod[31]}});

   // Completion waits at mul_cnt==1 while the cache stage is stalled.
   always_comb begin
      state_next   = state;
      mul_cnt_next = mul_cnt;
      case (state)
         IDLE: begin
            if (mul_start) begin
               state_next   = MUL_BUSY;
               mul_cnt_next = CNT_INIT;
            end
         end
         MUL_BUSY: begin
            if (mul_cnt == 4'd1) begin
               if (!cache_stall) begin
                  state_next   = IDLE;
                  mul_cnt_next = '0;
               end
            end else begin
               mul_cnt_next = mul_cnt - 4'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         mul_cnt <= '0;
         kill    <= 1'b0;
         replay  <= 1'b0;
         mul_a   <= '0;
         mul_b   <= '0;
         mul_pc  <= '0;
         mul_rd  <= '0;
      end else begin
         state   <= state_next;
         mul_cnt <= mul_cnt_next;
         // kill and replay stay armed until a cycle decode can actually advance
         kill    <= (accept & take) | (kill & cache_stall);
         replay  <= mul_done | (replay & cache_stall);
         if (mul_start) begin
            mul_a  <= ra;
            mul_b  <= rb;
            mul_pc <= req_to_alu_pc;
            mul_rd <= req_to_alu_info.rd_addr;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         branch_taken  <= 1'b0;
         branch_target <= '0;
      end else begin
         branch_taken  <= accept & take;
         branch_target <= (accept & take) ? (req_to_alu_pc + off) : '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         req_to_cache_valid   <= 1'b0;
         req_to_cache_opcode  <= '0;
         req_to_cache_rd_addr <= '0;
         req_to_cache_result  <= '0;
         req_to_cache_st_data <= '0;
         req_to_cache_pc      <= '0;
         xcpt_overflow        <= 1'b0;
      end else if (!cache_stall) begin
         if (mul_done) begin
            req_to_cache_valid   <= 1'b1;
            req_to_cache_opcode  <= OP_MUL;
            req_to_cache_rd_addr <= mul_rd;
            req_to_cache_result  <= mul_prod[31:0];
            req_to_cache_st_data <= '0;
            req_to_cache_pc      <= mul_pc;
            xcpt_overflow        <= mul_ovf;
         end else if (accept & writes) begin
            req_to_cache_valid   <= 1'b1;
            req_to_cache_opcode  <= op;
            req_to_cache_rd_addr <= req_to_alu_info.rd_addr;
            req_to_cache_result  <= alu_res;
            req_to_cache_st_data <= st_data;
            req_to_cache_pc      <= req_to_alu_pc;
            xcpt_overflow        <= alu_ovf;
         end else begin
            req_to_cache_valid   <= 1'b0;
            req_to_cache_opcode  <= '0;
            req_to_cache_rd_addr <= '0;
            req_to_cache_result  <= '0;
            req_to_cache_st_data <= '0;
            req_to_cache_pc      <= '0;
            xcpt_overflow        <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed test-plan cases plus a
// randomized decode-like stream compared against a cycle-level reference model.
module tb_alu_exec_stage;
   import alu_exec_pkg::*;

   localparam int unsigned LAT = 5;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         req_to_alu_valid = 1'b0;
   alu_request_t req_to_alu_info = '0;
   logic [31:0]  req_to_alu_pc = '0;
   logic         cache_stall = 1'b0;
   logic         stall_decode;
   logic [31:0]  alu_data_bypass;
   logic         branch_taken;
   logic [31:0]  branch_target;
   logic         req_to_cache_valid;
   logic [6:0]   req_to_cache_opcode;
   logic [4:0]   req_to_cache_rd_addr;
   logic [31:0]  req_to_cache_result;
   logic [31:0]  req_to_cache_st_data;
   logic [31:0]  req_to_cache_pc;
   logic         xcpt_overflow;

   alu_exec_stage #(.MUL_LATENCY(LAT)) dut (
      .clock                (clock),
      .reset                (reset),
      .req_to_alu_valid     (req_to_alu_valid),
      .req_to_alu_info      (req_to_alu_info),
      .req_to_alu_pc        (req_to_alu_pc),
      .cache_stall          (cache_stall),
      .stall_decode         (stall_decode),
      .alu_data_bypass      (alu_data_bypass),
      .branch_taken         (branch_taken),
      .branch_target        (branch_target),
      .req_to_cache_valid   (req_to_cache_valid),
      .req_to_cache_opcode  (req_to_cache_opcode),
      .req_to_cache_rd_addr (req_to_cache_rd_addr),
      .req_to_cache_result  (req_to_cache_result),
      .req_to_cache_st_data (req_to_cache_st_data),
      .req_to_cache_pc      (req_to_cache_pc),
      .xcpt_overflow        (xcpt_overflow)
   );

   always #5 clock = ~clock;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", tag, $time, got, exp);
   endtask

   // Reference model state (absolute cycle numbers, not a counter)
   int          cyc = 0;
   bit          m_active, m_kill, m_replay, m_stall;
   int          m_fin;
   logic [31:0] m_a, m_b, m_pc;
   logic [4:0]  m_rd;
   bit          e_valid, e_ovf, e_bt;
   logic [6:0]  e_op;
   logic [4:0]  e_rd;
   logic [31:0] e_res, e_st, e_pc, e_btgt;
   logic [31:0] s_bypass;
   bit          s_stall;

   task automatic model_clear();
      m_active = 0; m_kill = 0; m_replay = 0; m_stall = 0; m_fin = 0;
      m_a = '0; m_b = '0; m_pc = '0; m_rd = '0;
      e_valid = 0; e_ovf = 0; e_bt = 0; e_op = '0; e_rd = '0;
      e_res = '0; e_st = '0; e_pc = '0; e_btgt = '0;
   endtask

   task automatic ref_op(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] o, output logic [31:0] res, output bit ovf,
                         output bit wr, output bit byp, output bit tk);
      longint sa, sb, so, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      so = longint'($signed(o));
      r = 0; wr = 0; byp = 0; tk = 0;
      case (op)
         OP_ADD:  begin r = sa + sb; wr = 1; byp = 1; end
         OP_SUB:  begin r = sa - sb; wr = 1; byp = 1; end
         OP_ADDI: begin r = sa + so; wr = 1; byp = 1; end
         OP_LDB, OP_LDW, OP_STB, OP_STW: begin r = longint'(a + o); wr = 1; end
         OP_MUL:  r = sa * sb;
         OP_BEQ:  tk = (a == b);
         OP_JUMP: tk = 1;
         default: r = 0;
      endcase
      res = 32'(r);
      ovf = (op inside {OP_ADD, OP_SUB, OP_ADDI, OP_MUL}) &&
            (r > 64'sd2147483647 || r < -64'sd2147483648);
   endtask

   task automatic check_regs();
      check("valid",   32'(req_to_cache_valid),   32'(e_valid));
      check("opcode",  32'(req_to_cache_opcode),  32'(e_op));
      check("rd",      32'(req_to_cache_rd_addr), 32'(e_rd));
      check("result",  req_to_cache_result,       e_res);
      check("st_data", req_to_cache_st_data,      e_st);
      check("pc",      req_to_cache_pc,           e_pc);
      check("ovf",     32'(xcpt_overflow),        32'(e_ovf));
      check("br_tkn",  32'(branch_taken),         32'(e_bt));
      check("br_tgt",  branch_target,             e_btgt);
   endtask

   task automatic step();
      logic [31:0] res, mres;
      bit ovf, wr, byp, tk, movf, d1, d2, d3;
      bit v, is_mul, rhit, blk, stl, acc, start, done, cs;
      logic [6:0] op;
      @(negedge clock);
      v  = req_to_alu_valid;
      op = req_to_alu_info.opcode;
      cs = cache_stall;
      ref_op(op, req_to_alu_info.ra_data, req_to_alu_info.rb_data, req_to_alu_info.offset,
             res, ovf, wr, byp, tk);
      is_mul = v && op == OP_MUL;
      rhit   = m_replay && v && req_to_alu_pc == m_pc;
      blk    = m_kill || rhit;
      stl    = m_active || cs || (is_mul && !blk);
      acc    = v && !stl && !blk;
      start  = !m_active && is_mul && !blk && !cs;
      done   = m_active && cyc >= m_fin && !cs;
      s_bypass = alu_data_bypass;
      s_stall  = stall_decode;
      check("stall",  32'(stall_decode), 32'(stl));
      check("bypass", alu_data_bypass, (v && byp) ? res : 32'd0);
      @(posedge clock);
      #1;
      e_bt   = acc && tk;
      e_btgt = e_bt ? req_to_alu_pc + req_to_alu_info.offset : 32'd0;
      if (!cs) begin
         if (done) begin
            ref_op(OP_MUL, m_a, m_b, 32'd0, mres, movf, d1, d2, d3);
            e_valid = 1; e_op = OP_MUL; e_rd = m_rd; e_res = mres;
            e_st = '0; e_pc = m_pc; e_ovf = movf;
         end else if (acc && wr) begin
            e_valid = 1; e_op = op; e_rd = req_to_alu_info.rd_addr; e_res = res;
            e_st = (op == OP_STB || op == OP_STW) ? req_to_alu_info.rb_data : 32'd0;
            e_pc = req_to_alu_pc; e_ovf = ovf;
         end else begin
            e_valid = 0; e_op = '0; e_rd = '0; e_res = '0; e_st = '0; e_pc = '0; e_ovf = 0;
         end
      end
      m_kill   = e_bt || (m_kill && cs);
      m_replay = done || (m_replay && cs);
      if (done) m_active = 0;
      if (start) begin
         m_active = 1; m_fin = cyc + int'(LAT) - 1;
         m_a = req_to_alu_info.ra_data; m_b = req_to_alu_info.rb_data;
         m_pc = req_to_alu_pc; m_rd = req_to_alu_info.rd_addr;
      end
      m_stall = stl;
      cyc++;
      check_regs();
   endtask

   task automatic drive(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] o, input logic [4:0] rd, input logic [31:0] pc,
                        input bit cs);
      req_to_alu_valid        = 1'b1;
      req_to_alu_info.opcode  = op;
      req_to_alu_info.rd_addr = rd;
      req_to_alu_info.ra_addr = 5'd1;
      req_to_alu_info.ra_data = a;
      req_to_alu_info.rb_data = b;
      req_to_alu_info.offset  = o;
      req_to_alu_pc           = pc;
      cache_stall             = cs;
   endtask

   task automatic idle(input bit cs);
      req_to_alu_valid = 1'b0;
      req_to_alu_info  = '0;
      req_to_alu_pc    = '0;
      cache_stall      = cs;
   endtask

   task automatic apply_reset();
      @(negedge clock);
      #2;
      reset = 1'b0;
      idle(0);
      #1;
      model_clear();
      check_regs();
      check("rst_stall",  32'(stall_decode), 32'd0);
      check("rst_bypass", alu_data_bypass, 32'd0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned nres;
      logic [31:0] next_pc;
      bit have;
      logic [6:0] r_op;
      logic [31:0] r_a, r_b, r_o, r_pc;
      logic [4:0] r_rd;

      model_clear();
      apply_reset();

      // ADD 7+5
      drive(OP_ADD, 32'd7, 32'd5, 32'd0, 5'd3, 32'h100, 0); step();
      check("tp_add_bypass", s_bypass, 32'd12);
      check("tp_add_valid",  32'(req_to_cache_valid), 32'd1);
      check("tp_add_res",    req_to_cache_result, 32'd12);
      check("tp_add_rd",     32'(req_to_cache_rd_addr), 32'd3);
      check("tp_add_pc",     req_to_cache_pc, 32'h100);

      // ADD overflow
      drive(OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 5'd4, 32'h104, 0); step();
      check("tp_ovf_res", req_to_cache_result, 32'h8000_0000);
      check("tp_ovf_flag", 32'(xcpt_overflow), 32'd1);

      // MUL 6*7 held by decode for LAT cycles, then replayed once
      nres = 0;
      for (int k = 0; k <= int'(LAT); k++) begin
         drive(OP_MUL, 32'd6, 32'd7, 32'd0, 5'd9, 32'h300, 0); step();
         check("tp_mul_stall", 32'(s_stall), (k < int'(LAT)) ? 32'd1 : 32'd0);
         if (req_to_cache_valid) begin
            nres++;
            check("tp_mul_res", req_to_cache_result, 32'd42);
         end
         if (k == int'(LAT) - 1) check("tp_mul_at_lat", 32'(req_to_cache_valid), 32'd1);
      end
      idle(0); step();
      check("tp_mul_once", 32'(nres), 32'd1);

      // BEQ taken kills the next request; BEQ not taken lets it run
      drive(OP_BEQ, 32'd9, 32'd9, 32'h10, 5'd0, 32'h200, 0); step();
      check("tp_beq_taken", 32'(branch_taken), 32'd1);
      check("tp_beq_tgt",   branch_target, 32'h210);
      drive(OP_ADD, 32'd3, 32'd4, 32'd0, 5'd5, 32'h204, 0); step();
      check("tp_kill_stall", 32'(s_stall), 32'd0);
      check("tp_kill_valid", 32'(req_to_cache_valid), 32'd0);
      drive(OP_BEQ, 32'd9, 32'd8, 32'h10, 5'd0, 32'h208, 0); step();
      check("tp_beq_nt", 32'(branch_taken), 32'd0);
      drive(OP_ADD, 32'd3, 32'd4, 32'd0, 5'd5, 32'h20C, 0); step();
      check("tp_nt_valid", 32'(req_to_cache_valid), 32'd1);
      check("tp_nt_res",   req_to_cache_result, 32'd7);

      // STW held by cache_stall
      drive(OP_STW, 32'h1000, 32'hDEAD, 32'd8, 5'd0, 32'h400, 0); step();
      for (int k = 0; k < 3; k++) begin
         drive(OP_ADD, 32'd1, 32'd2, 32'd0, 5'd6, 32'h404, 1); step();
         check("tp_st_stall", 32'(s_stall), 32'd1);
         check("tp_st_valid", 32'(req_to_cache_valid), 32'd1);
         check("tp_st_addr",  req_to_cache_result, 32'h1008);
         check("tp_st_data",  req_to_cache_st_data, 32'hDEAD);
      end
      drive(OP_ADD, 32'd1, 32'd2, 32'd0, 5'd6, 32'h404, 0); step();
      check("tp_st_release", req_to_cache_result, 32'd3);

      // Reset in the middle of a MUL
      drive(OP_MUL, 32'd6, 32'd7, 32'd0, 5'd9, 32'h500, 0); step();
      drive(OP_MUL, 32'd6, 32'd7, 32'd0, 5'd9, 32'h500, 0); step();
      apply_reset();
      drive(OP_ADD, 32'd1, 32'd1, 32'd0, 5'd2, 32'h600, 0); step();
      check("tp_rst_add", req_to_cache_result, 32'd2);
      nres = 0;
      for (int k = 0; k < int'(LAT) + 2; k++) begin
         idle(0); step();
         if (req_to_cache_valid) nres++;
      end
      check("tp_rst_no_mul", 32'(nres), 32'd0);

      // Randomized decode-like stream: a request is held while stall was predicted
      next_pc = 32'h1000;
      have = 0;
      r_op = OP_NOP; r_a = '0; r_b = '0; r_o = '0; r_rd = '0; r_pc = '0;
      for (int i = 0; i < 3000; i++) begin
         if (!have || !m_stall) begin
            case ($urandom_range(0, 11))
               0: r_op = OP_NOP;   1: r_op = OP_ADD;  2: r_op = OP_SUB;
               3: r_op = OP_MUL;   4: r_op = OP_ADDI; 5: r_op = OP_LDB;
               6: r_op = OP_LDW;   7: r_op = OP_STB;  8: r_op = OP_STW;
               9: r_op = OP_BEQ;   10: r_op = OP_JUMP;
               default: r_op = 7'h7F;
            endcase
            r_a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom();
            r_b  = ($urandom_range(0, 3) == 0) ? r_a : $urandom();
            r_o  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom();
            r_rd = 5'($urandom_range(0, 31));
            r_pc = next_pc;
            next_pc += 32'd4;
            have = 1;
         end
         if ($urandom_range(0, 9) == 0) idle($urandom_range(0, 99) < 12);
         else drive(r_op, r_a, r_b, r_o, r_rd, r_pc, $urandom_range(0, 99) < 12);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Execute stage receiving the `alu_request_t` stream produced by decode. It computes arithmetic, address and branch results and drives `alu_data_bypass` back to decode in the same cycle. It runs a multi-cycle multiplier and generates `stall_decode`, and registers results toward the cache/writeback stage. It is the responder end of the decode→ALU interface, including the stall/hazard and bypass handshake.

## Interface
- `MUL_LATENCY`, default 5: cycles from MUL acceptance to a valid result on the output registers. Legal values are 2..16.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `req_to_alu_valid`  in  1  request valid from decode.
- `req_to_alu_info`  in  alu_request_t  opcode, rd_addr, ra_addr, ra_data, rb_data, offset.
- `req_to_alu_pc`  in  `PC_WIDTH` (32)  PC of the request.
- `cache_stall`  in  1  cache stage cannot accept a new result this cycle.
- `stall_decode`  out  1  decode must hold; drives decode's `stall_decode`.
- `alu_data_bypass`  out  32  combinational result of the request currently presented.
- `branch_taken`  out  1  registered one-cycle pulse when a redirect is required.
- `branch_target`  out  32  redirect PC, valid with `branch_taken`.
- `req_to_cache_valid`  out  1  registered result valid.
- `req_to_cache_opcode`  out  7  opcode of the result.
- `req_to_cache_rd_addr`  out  5  destination register.
- `req_to_cache_result`  out  32  ALU result, or memory address for M-type.
- `req_to_cache_st_data`  out  32  store data (rb_data) for STB/STW, else 0.
- `req_to_cache_pc`  out  32  PC of the result.
- `xcpt_overflow`  out  1  registered signed overflow, aligned with `req_to_cache_valid`.

## Operation
- States: IDLE and MUL_BUSY. A 4-bit down-counter `mul_cnt` runs during MUL_BUSY.
- Accept condition: `req_to_alu_valid & !stall_decode & !kill`.
- Result rules (32-bit, results wrap):
  - ADD: ra+rb.
  - SUB: ra−rb.
  - ADDI: ra+offset.
  - LDB/LDW/STB/STW: address ra+offset.
  - MUL: low 32 bits of the signed 64-bit product.
  - BEQ/JUMP: result 0.
- Overflow:
  - ADD/ADDI/SUB: signed overflow of the 32-bit operation.
  - MUL: the signed product does not fit in 32 bits.
  - All other opcodes: 0.
- `alu_data_bypass` is the combinational R-type/ADDI result of the current input. It is 0 for M-type, branch and NOP, and for MUL before completion.
- BEQ: taken iff ra_data == rb_data. JUMP: always taken. Target is req_to_alu_pc + offset.
- A taken branch sets `kill` for the next cycle. Any request presented in that cycle is dropped, with no output and no stall.
- NOP and BEQ/JUMP produce no `req_to_cache_valid`.
- MUL sequence:
  - In IDLE, a valid MUL is latched (operands, rd, pc) and the block moves to MUL_BUSY with `mul_cnt = MUL_LATENCY-1`.
  - In MUL_BUSY, `mul_cnt` decrements every cycle, and input requests are ignored (not accepted, no side effects).
  - At `mul_cnt==1` the result is registered to the outputs and the block returns to IDLE.
- `stall_decode` = (IDLE & valid MUL presented) | MUL_BUSY | `cache_stall`.
- Hazard-replay filter: decode re-presents the held request on the cycle stall_decode falls. In the cycle after MUL completion, a request whose PC equals the completed MUL PC is dropped.
- While `cache_stall`=1, all output registers hold and no new request is accepted.
- If `cache_stall` is asserted when a MUL finishes, the FSM stays in MUL_BUSY with `mul_cnt`=1 until `cache_stall` falls.

## Timing
- Reset values: all outputs 0, state IDLE, `mul_cnt` 0, `kill` 0.
- Reset mid-MUL aborts it. After release, no result or pulse is emitted for the aborted MUL.
- Single-cycle ops: accepted in cycle N, `req_to_cache_*` and `xcpt_overflow` valid in N+1 for exactly one cycle unless held by `cache_stall`.
- `alu_data_bypass` is valid in cycle N itself, combinationally.
- `branch_taken`/`branch_target` are registered at N+1 for one cycle. `kill` covers cycle N+1.
- MUL accepted in N: `stall_decode` is high N..N+MUL_LATENCY-1, and the result is valid at N+MUL_LATENCY.
- Back-to-back single-cycle ops give one result per cycle.
- A MUL immediately following an ADD starts in the cycle it is presented.
- Simultaneous `cache_stall` with a new request: the request is not accepted, and `stall_decode` is 1.

## Test plan
- ADD ra=7, rb=5, rd=3, pc=0x100 -> `alu_data_bypass`=12 in the same cycle; next cycle `req_to_cache_valid`=1, result=12, rd=3, pc=0x100.
- ADD ra=0x7FFFFFFF, rb=1 -> result 0x80000000, `xcpt_overflow`=1.
- MUL ra=6, rb=7 at cycle N with MUL_LATENCY=5 -> `stall_decode` high N..N+4; result 42 at N+5; replayed MUL (same PC) at N+5 dropped; only one result emitted.
- BEQ ra=rb=9, pc=0x200, offset=0x10 -> `branch_taken`=1, target 0x210 next cycle; the ADD presented in that cycle produces no output. BEQ with ra≠rb -> no pulse, and the following ADD executes.
- STW ra=0x1000, offset=8, rb=0xDEAD held with `cache_stall`=1 for 3 cycles -> outputs stable, address 0x1008, st_data 0xDEAD, `stall_decode`=1 throughout.
- Reset low at MUL cycle N+2 -> all outputs 0 immediately; after release, an ADD 1+1 yields 2 and no MUL result ever appears.
